// File: rtl/random_ctrl.sv
// Sequencer/arbiter for the 4-stage JK random bit generator: programs the tap code,
// seeds the generator, gathers serial bits into words and grants them round-robin.
module random_ctrl #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned SEED_CYC  = 4,
   parameter int unsigned FLUSH_CYC = 8,
   parameter int unsigned STUCK_LIM = 12,
   parameter logic [2:0]  RST_CODE  = 3'b011
) (
   input  logic             Cp,
   input  logic             R,
   input  logic             cfg_we,
   input  logic [2:0]       cfg_code,
   input  logic             req0,
   input  logic             req1,
   input  logic             rnd_bit,
   output logic [2:0]       gen_code,
   output logic             gen_S,
   output logic             gnt0,
   output logic             gnt1,
   output logic             word_valid,
   output logic [WIDTH-1:0] word_data,
   output logic             busy,
   output logic             stuck_err
);

   typedef enum logic [2:0] {IDLE, SEED, FLUSH, GATHER, DELIVER} state_t;

   state_t      state;
   logic [31:0] cnt;
   logic [31:0] run;
   logic [31:0] run_nxt;
   logic        prev_bit;
   logic        stuck_hit;
   logic        pend;
   logic [2:0]  pend_code;
   logic        ptr;
   logic        winner;
   logic        retry;
   logic        win_nxt;

   always_comb begin
      run_nxt   = ((run != '0) && (rnd_bit == prev_bit)) ? run + 32'd1 : 32'd1;
      stuck_hit = (run_nxt >= STUCK_LIM);
      // A requester whose word was discarded by lock-up keeps its win on retry.
      if (retry && (winner ? req1 : req0))
         win_nxt = winner;
      else if (req0 && req1)
         win_nxt = ptr;
      else
         win_nxt = req1;
   end

   always_ff @(posedge Cp) begin
      if (R) begin
         state      <= SEED;
         cnt        <= '0;
         run        <= '0;
         prev_bit   <= 1'b0;
         gen_code   <= RST_CODE;
         gen_S      <= 1'b1;
         busy       <= 1'b1;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         word_valid <= 1'b0;
         word_data  <= '0;
         stuck_err  <= 1'b0;
         pend       <= 1'b0;
         pend_code  <= '0;
         ptr        <= 1'b0;
         winner     <= 1'b0;
         retry      <= 1'b0;
      end else begin
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         word_valid <= 1'b0;
         if (cfg_we)
            stuck_err <= 1'b0;

         case (state)
            IDLE: begin
               if (pend) begin
                  gen_code <= pend_code;
                  pend     <= 1'b0;
                  state    <= SEED;
                  cnt      <= '0;
                  run      <= '0;
                  gen_S    <= 1'b1;
                  busy     <= 1'b1;
               end else if (req0 || req1) begin
                  winner <= win_nxt;
                  state  <= GATHER;
                  cnt    <= '0;
                  busy   <= 1'b1;
               end
            end

            SEED: begin
               if (cnt == SEED_CYC - 1) begin
                  cnt   <= '0;
                  gen_S <= 1'b0;
                  if (FLUSH_CYC == 0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= FLUSH;
                  end
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            FLUSH: begin
               run      <= run_nxt;
               prev_bit <= rnd_bit;
               if (stuck_hit) begin
                  stuck_err <= 1'b1;
                  state     <= SEED;
                  cnt       <= '0;
                  run       <= '0;
                  gen_S     <= 1'b1;
               end else if (cnt == FLUSH_CYC - 1) begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            GATHER: begin
               run       <= run_nxt;
               prev_bit  <= rnd_bit;
               word_data <= {word_data[WIDTH-2:0], rnd_bit};
               // Lock-up wins over word completion: the partial word is dropped.
               if (stuck_hit) begin
                  stuck_err <= 1'b1;
                  retry     <= 1'b1;
                  state     <= SEED;
                  cnt       <= '0;
                  run       <= '0;
                  gen_S     <= 1'b1;
               end else if (cnt == WIDTH - 1) begin
                  state      <= DELIVER;
                  cnt        <= '0;
                  word_valid <= 1'b1;
                  gnt0       <= ~winner;
                  gnt1       <= winner;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            DELIVER: begin
               ptr   <= ~winner;
               retry <= 1'b0;
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= SEED;
               cnt   <= '0;
               run   <= '0;
               gen_S <= 1'b1;
               busy  <= 1'b1;
            end
         endcase

         if (cfg_we) begin
            pend      <= 1'b1;
            pend_code <= cfg_code;
         end
      end
   end

endmodule
